// File: rtl/case_conv_pkg.sv
// Shared encodings for the case-conversion scheduler: modes, FSM states, letter ranges.
// No logic; purely type and constant definitions.
// No flow control of its own.
package case_conv_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_UPPER  = 2'b01,
    MODE_LOWER  = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  localparam logic [7:0] UPPER_LO = 8'h41;
  localparam logic [7:0] UPPER_HI = 8'h5A;
  localparam logic [7:0] LOWER_LO = 8'h61;
  localparam logic [7:0] LOWER_HI = 8'h7A;
  localparam int         CASE_BIT = 5;

endpackage

// File: rtl/ascii_case_map.sv
// ASCII case mapper: flips bit 5 of letters according to mode; non-letters pass.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module ascii_case_map
  import case_conv_pkg::*;
(
  input  logic [7:0] in_byte,
  input  logic [1:0] mode,
  output logic [7:0] out_byte,
  output logic       changed
);

  logic is_upper;
  logic is_lower;
  logic flip;

  assign is_upper = (in_byte >= UPPER_LO) && (in_byte <= UPPER_HI);
  assign is_lower = (in_byte >= LOWER_LO) && (in_byte <= LOWER_HI);

  assign flip = ((mode == MODE_UPPER)  && is_lower) ||
                ((mode == MODE_LOWER)  && is_upper) ||
                ((mode == MODE_TOGGLE) && (is_upper || is_lower));

  assign out_byte = in_byte ^ (8'(flip) << CASE_BIT);
  assign changed  = flip;

endmodule

// File: rtl/case_conv_sched.sv
// Two-requester round-robin scheduler feeding one case-conversion datapath, whole strings per grant.
// Latency: 1 cycle from accept to registered output slot; 1 idle cycle between strings.
// Backpressure: granted req_ready follows slot_free (empty slot or downstream taking it this cycle).
module case_conv_sched
  import case_conv_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [1:0]       req_valid,
  input  logic [15:0]      req_data,
  input  logic [1:0]       req_last,
  output logic [1:0]       req_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] str_cnt,
  output logic [CNT_W-1:0] chg_cnt,
  output logic             len_err,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             rr_q, rr_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] run_str_q, run_str_d;
  logic [CNT_W-1:0] run_chg_q, run_chg_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_src_q, out_src_d;
  logic [CNT_W-1:0] str_cnt_q, str_cnt_d;
  logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;
  logic             len_err_q, len_err_d;

  logic [7:0]       gnt_byte;
  logic [7:0]       map_byte;
  logic             map_chg;
  logic             gnt_valid;
  logic             gnt_last;
  logic             slot_free;
  logic             accept;
  logic             forced;
  logic [CNT_W-1:0] str_next;
  logic [CNT_W-1:0] chg_next;

  assign gnt_byte  = grant_q ? req_data[15:8] : req_data[7:0];
  assign gnt_valid = req_valid[grant_q];
  assign gnt_last  = req_last[grant_q];
  assign slot_free = !out_valid_q || out_ready;

  ascii_case_map u_map (
    .in_byte  (gnt_byte),
    .mode     (mode_q),
    .out_byte (map_byte),
    .changed  (map_chg)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    mode_d      = mode_q;
    run_str_d   = run_str_q;
    run_chg_d   = run_chg_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    str_cnt_d   = str_cnt_q;
    chg_cnt_d   = chg_cnt_q;
    len_err_d   = 1'b0;
    req_ready   = 2'b00;
    accept      = 1'b0;
    forced      = 1'b0;
    str_next    = run_str_q + CNT_W'(1);
    chg_next    = run_chg_q + CNT_W'(map_chg);

    // A drained slot empties unless refilled below in the same cycle.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_d   = req_valid[rr_q] ? rr_q : ~rr_q;
          mode_d    = mode;
          run_str_d = '0;
          run_chg_d = '0;
          state_d   = ST_STREAM;
        end
      end
      ST_STREAM: begin
        req_ready[grant_q] = slot_free;
        accept = gnt_valid && slot_free;
        if (accept) begin
          forced      = !gnt_last && (str_next == CNT_W'(MAX_LEN));
          run_str_d   = str_next;
          run_chg_d   = chg_next;
          out_valid_d = 1'b1;
          out_data_d  = map_byte;
          out_last_d  = gnt_last || forced;
          out_src_d   = grant_q;
          str_cnt_d   = str_next;
          chg_cnt_d   = chg_next;
          len_err_d   = forced;
          if (gnt_last || forced) begin
            state_d = ST_IDLE;
            rr_d    = ~grant_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= 1'b0;
      rr_q        <= 1'b0;
      mode_q      <= 2'b00;
      run_str_q   <= '0;
      run_chg_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
      str_cnt_q   <= '0;
      chg_cnt_q   <= '0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      mode_q      <= mode_d;
      run_str_q   <= run_str_d;
      run_chg_q   <= run_chg_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
      str_cnt_q   <= str_cnt_d;
      chg_cnt_q   <= chg_cnt_d;
      len_err_q   <= len_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
  assign str_cnt   = str_cnt_q;
  assign chg_cnt   = chg_cnt_q;
  assign len_err   = len_err_q;
  assign busy      = (state_q == ST_STREAM);

endmodule

// File: tb/tb_case_conv_sched.sv
// Randomized bench for case_conv_sched with a string-level reference model and directed scenarios.
module tb_case_conv_sched;

  localparam int ML = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    mode;
  logic [1:0]    req_valid;
  logic [15:0]   req_data;
  logic [1:0]    req_last;
  logic [1:0]    req_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_last;
  logic          out_src;
  logic          out_ready;
  logic [CW-1:0] str_cnt;
  logic [CW-1:0] chg_cnt;
  logic          len_err;
  logic          busy;

  case_conv_sched #(.MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready), .str_cnt(str_cnt), .chg_cnt(chg_cnt), .len_err(len_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] d; logic l;} bt_t;
  typedef struct {logic [7:0] d; logic l; logic s; logic [CW-1:0] sc; logic [CW-1:0] cc; logic le; int cyc;} ob_t;

  bt_t src0[$], src1[$];
  ob_t exp0[$], exp1[$], obs_log[$];
  int  mcnt[2], mchg[2];
  int  valid_pct, ready_pct, cyc, vec_cnt, err_cnt, le_pulses, exp_forced;
  logic prev_stall;
  logic [10+2*CW:0] prev_snap;

  function automatic logic [7:0] conv(input logic [7:0] b, input logic [1:0] m);
    bit up, lo;
    up = (b >= 8'h41) && (b <= 8'h5A);
    lo = (b >= 8'h61) && (b <= 8'h7A);
    case (m)
      2'd1:    return lo ? b - 8'd32 : b;
      2'd2:    return up ? b + 8'd32 : b;
      2'd3:    return up ? b + 8'd32 : (lo ? b - 8'd32 : b);
      default: return b;
    endcase
  endfunction

  function automatic logic [7:0] rnd_byte();
    logic [7:0] edges [4];
    edges = '{8'h40, 8'h5B, 8'h60, 8'h7B};
    case ($urandom_range(3))
      0:       return 8'h41 + 8'($urandom_range(25));
      1:       return 8'h61 + 8'($urandom_range(25));
      2:       return 8'($urandom_range(255));
      default: return edges[$urandom_range(3)];
    endcase
  endfunction

  // Model: each requester's byte stream splits into strings at last or at ML bytes.
  task automatic add_byte(input int r, input logic [7:0] b, input logic l, input logic [1:0] m);
    bt_t t;
    ob_t e;
    e.d = conv(b, m);
    mcnt[r]++;
    if (e.d != b) mchg[r]++;
    e.le  = !l && (mcnt[r] == ML);
    e.l   = l || e.le;
    e.s   = r[0];
    e.sc  = CW'(mcnt[r]);
    e.cc  = CW'(mchg[r]);
    e.cyc = 0;
    if (e.le) exp_forced++;
    if (e.l) begin mcnt[r] = 0; mchg[r] = 0; end
    t.d = b;
    t.l = l;
    if (r == 0) begin src0.push_back(t); exp0.push_back(e); end
    else        begin src1.push_back(t); exp1.push_back(e); end
  endtask

  task automatic add_str(input int r, input int len, input logic [1:0] m);
    for (int i = 0; i < len; i++) add_byte(r, rnd_byte(), (i == len - 1), m);
  endtask

  task automatic cycle();
    logic [1:0] acc;
    logic [10+2*CW:0] snap;
    ob_t o, e;
    req_valid = 2'b00; req_data = 16'h0; req_last = 2'b00;
    if (src0.size() > 0 && int'($urandom_range(99)) < valid_pct) begin
      req_valid[0] = 1'b1; req_data[7:0] = src0[0].d; req_last[0] = src0[0].l;
    end
    if (src1.size() > 0 && int'($urandom_range(99)) < valid_pct) begin
      req_valid[1] = 1'b1; req_data[15:8] = src1[0].d; req_last[1] = src1[0].l;
    end
    out_ready = (int'($urandom_range(99)) < ready_pct);
    #1;
    snap = {out_valid, out_data, out_last, out_src, str_cnt, chg_cnt};
    if (prev_stall) begin
      vec_cnt++;
      if (snap !== prev_snap) begin
        err_cnt++; $display("FAIL hold: got %h want %h", snap, prev_snap);
      end
    end
    vec_cnt++;
    if (!$onehot0(req_ready) || (req_ready != 2'b00 && out_valid && !out_ready)) begin
      err_cnt++; $display("FAIL ready_rule: req_ready=%b out_valid=%b out_ready=%b", req_ready, out_valid, out_ready);
    end
    prev_stall = out_valid && !out_ready;
    prev_snap  = snap;
    if (len_err) le_pulses++;
    acc = req_valid & req_ready;
    if (out_valid && out_ready) begin
      o.d = out_data; o.l = out_last; o.s = out_src; o.sc = str_cnt; o.cc = chg_cnt; o.le = len_err; o.cyc = cyc;
      obs_log.push_back(o);
      vec_cnt++;
      if ((out_src ? exp1.size() : exp0.size()) == 0) begin
        err_cnt++; $display("FAIL unexpected: src%0d byte %h, want no byte", out_src, out_data);
      end else begin
        if (out_src) e = exp1.pop_front(); else e = exp0.pop_front();
        if (o.d !== e.d || o.l !== e.l || (e.l && (o.sc !== e.sc || o.cc !== e.cc))) begin
          err_cnt++;
          $display("FAIL byte src%0d: got d=%h l=%b sc=%0d cc=%0d, want d=%h l=%b sc=%0d cc=%0d",
                   o.s, o.d, o.l, o.sc, o.cc, e.d, e.l, e.sc, e.cc);
        end
      end
    end
    @(posedge clk); #1;
    cyc++;
    if (acc[0]) void'(src0.pop_front());
    if (acc[1]) void'(src1.pop_front());
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((src0.size() + src1.size() + exp0.size() + exp1.size()) != 0 && n < budget) begin
      cycle(); n++;
    end
    vec_cnt++;
    if (n >= budget) begin
      err_cnt++;
      $display("FAIL drain_timeout: %0d items left after %0d cycles, want 0",
               src0.size() + src1.size() + exp0.size() + exp1.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 2'b00; req_valid = 2'b00; req_data = 16'h0; req_last = 2'b00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++;
    if ({out_valid, out_data, out_last, out_src, req_ready, str_cnt, chg_cnt, len_err, busy} !== '0) begin
      err_cnt++; $display("FAIL reset: outputs %h, want 0",
                          {out_valid, out_data, out_last, out_src, req_ready, str_cnt, chg_cnt, len_err, busy});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    vec_cnt++;
    if ({out_valid, req_ready, busy} !== 4'b0) begin
      err_cnt++; $display("FAIL reset_release: valid/ready/busy %b, want 0000", {out_valid, req_ready, busy});
    end
  endtask

  task automatic test_arb();
    mode = 2'b11; obs_log.delete();
    add_byte(0, 8'h62, 1'b1, 2'b11);
    add_byte(1, 8'h43, 1'b1, 2'b11);
    valid_pct = 100; ready_pct = 100;
    drain(50);
    vec_cnt++;
    if (obs_log.size() != 2 || obs_log[0].d !== 8'h42 || obs_log[0].s !== 1'b0 ||
        obs_log[1].d !== 8'h63 || obs_log[1].s !== 1'b1 || obs_log[1].cyc - obs_log[0].cyc != 2) begin
      err_cnt++; $display("FAIL arb: got n=%0d %h/src%0d %h/src%0d gap %0d, want 42/src0 63/src1 gap 2",
                          obs_log.size(), obs_log[0].d, obs_log[0].s, obs_log[1].d, obs_log[1].s,
                          obs_log[1].cyc - obs_log[0].cyc);
    end
  endtask

  task automatic test_upper();
    mode = 2'b01; obs_log.delete();
    add_byte(0, 8'h61, 1'b0, 2'b01);
    add_byte(0, 8'h7B, 1'b0, 2'b01);
    add_byte(0, 8'h5A, 1'b1, 2'b01);
    valid_pct = 100; ready_pct = 100;
    cycle();
    vec_cnt++;
    if (busy !== 1'b1) begin err_cnt++; $display("FAIL busy_stream: got %b want 1", busy); end
    drain(50);
    vec_cnt++;
    if (obs_log.size() != 3 || {obs_log[0].d, obs_log[1].d, obs_log[2].d} !== 24'h417B5A ||
        {obs_log[0].l, obs_log[1].l, obs_log[2].l} !== 3'b001) begin
      err_cnt++; $display("FAIL upper_data: got %h%h%h last %b%b%b, want 417b5a last 001",
                          obs_log[0].d, obs_log[1].d, obs_log[2].d, obs_log[0].l, obs_log[1].l, obs_log[2].l);
    end
    vec_cnt++;
    if (obs_log[2].sc !== CW'(3) || obs_log[2].cc !== CW'(1) || obs_log[2].s !== 1'b0 ||
        obs_log[2].cyc - obs_log[0].cyc != 2) begin
      err_cnt++; $display("FAIL upper_counts: got str=%0d chg=%0d src=%0d span=%0d, want 3 1 0 2",
                          obs_log[2].sc, obs_log[2].cc, obs_log[2].s, obs_log[2].cyc - obs_log[0].cyc);
    end
    vec_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_hold();
    mode = 2'b10; obs_log.delete();
    add_byte(1, 8'h41, 1'b0, 2'b10);
    add_byte(1, 8'h42, 1'b1, 2'b10);
    valid_pct = 100; ready_pct = 0;
    for (int k = 0; k < 10 && !out_valid; k++) cycle();
    for (int k = 0; k < 3; k++) begin
      vec_cnt++;
      if (out_valid !== 1'b1 || out_data !== 8'h61 || req_ready !== 2'b00) begin
        err_cnt++; $display("FAIL hold_stall: got valid=%b data=%h ready=%b, want 1 61 00",
                            out_valid, out_data, req_ready);
      end
      cycle();
    end
    ready_pct = 100;
    drain(20);
    vec_cnt++;
    if (obs_log.size() != 2 || obs_log[0].d !== 8'h61 || obs_log[1].d !== 8'h62 ||
        obs_log[1].cyc - obs_log[0].cyc != 1) begin
      err_cnt++; $display("FAIL hold_release: got n=%0d %h %h gap %0d, want 2 61 62 gap 1",
                          obs_log.size(), obs_log[0].d, obs_log[1].d, obs_log[1].cyc - obs_log[0].cyc);
    end
  endtask

  task automatic test_maxlen();
    mode = 2'b11; obs_log.delete(); le_pulses = 0;
    for (int i = 0; i < 6; i++) add_byte(0, rnd_byte(), (i == 5), 2'b11);
    add_byte(1, rnd_byte(), 1'b1, 2'b11);
    valid_pct = 100; ready_pct = 100;
    drain(100);
    vec_cnt++;
    if (obs_log.size() != 7 || obs_log[2].l !== 1'b0 || obs_log[3].l !== 1'b1 ||
        obs_log[3].sc !== CW'(4) || obs_log[3].le !== 1'b1 || obs_log[3].s !== 1'b0) begin
      err_cnt++; $display("FAIL maxlen_cut: got n=%0d last3=%b last4=%b str=%0d len_err=%b, want 7 0 1 4 1",
                          obs_log.size(), obs_log[2].l, obs_log[3].l, obs_log[3].sc, obs_log[3].le);
    end
    vec_cnt++;
    if (le_pulses != 1) begin err_cnt++; $display("FAIL len_err_pulses: got %0d want 1", le_pulses); end
    vec_cnt++;
    if (obs_log[4].s !== 1'b1 || obs_log[5].s !== 1'b0 || obs_log[6].sc !== CW'(2) || obs_log[6].l !== 1'b1) begin
      err_cnt++; $display("FAIL maxlen_rearb: got src5=%0d src6=%0d str7=%0d, want 1 0 2",
                          obs_log[4].s, obs_log[5].s, obs_log[6].sc);
    end
  endtask

  task automatic test_mode_switch();
    mode = 2'b01; obs_log.delete();
    add_byte(0, 8'h78, 1'b0, 2'b01); add_byte(0, 8'h79, 1'b0, 2'b01); add_byte(0, 8'h7A, 1'b1, 2'b01);
    add_byte(0, 8'h78, 1'b0, 2'b00); add_byte(0, 8'h79, 1'b0, 2'b00); add_byte(0, 8'h7A, 1'b1, 2'b00);
    valid_pct = 100; ready_pct = 100;
    cycle(); cycle();
    mode = 2'b00;
    drain(50);
    vec_cnt++;
    if (obs_log.size() != 6 ||
        {obs_log[0].d, obs_log[1].d, obs_log[2].d, obs_log[3].d, obs_log[4].d, obs_log[5].d} !== 48'h58595A78797A) begin
      err_cnt++; $display("FAIL mode_switch: got %h%h%h %h%h%h, want 58595a 78797a",
                          obs_log[0].d, obs_log[1].d, obs_log[2].d, obs_log[3].d, obs_log[4].d, obs_log[5].d);
    end
  endtask

  task automatic test_async_reset();
    mode = 2'b00;
    for (int i = 0; i < 3; i++) add_byte(0, rnd_byte(), 1'b0, 2'b00);
    valid_pct = 100; ready_pct = 100;
    repeat (3) cycle();
    #2;
    rst_n = 1'b0;
    req_valid = 2'b00; req_last = 2'b00;
    #1;
    vec_cnt++;
    if ({out_valid, out_data, out_last, out_src, req_ready, str_cnt, chg_cnt, len_err, busy} !== '0) begin
      err_cnt++; $display("FAIL async_reset: outputs %h, want 0",
                          {out_valid, out_data, out_last, out_src, req_ready, str_cnt, chg_cnt, len_err, busy});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    src0.delete(); src1.delete(); exp0.delete(); exp1.delete(); obs_log.delete();
    mcnt[0] = 0; mcnt[1] = 0; mchg[0] = 0; mchg[1] = 0;
    prev_stall = 1'b0;
    add_byte(0, 8'h71, 1'b1, 2'b00);
    add_byte(1, 8'h72, 1'b1, 2'b00);
    drain(50);
    vec_cnt++;
    if (obs_log.size() != 2 || obs_log[0].s !== 1'b0 || obs_log[0].d !== 8'h71 ||
        obs_log[0].sc !== CW'(1) || obs_log[1].s !== 1'b1) begin
      err_cnt++; $display("FAIL post_reset: got n=%0d src=%0d d=%h str=%0d next_src=%0d, want 2 0 71 1 1",
                          obs_log.size(), obs_log[0].s, obs_log[0].d, obs_log[0].sc, obs_log[1].s);
    end
  endtask

  task automatic test_random();
    for (int rnd = 0; rnd < 4; rnd++) begin
      mode = 2'(rnd); le_pulses = 0; exp_forced = 0;
      for (int s = 0; s < 5; s++) begin
        add_str(0, $urandom_range(1, 7), 2'(rnd));
        add_str(1, $urandom_range(1, 7), 2'(rnd));
      end
      valid_pct = $urandom_range(50, 90); ready_pct = $urandom_range(40, 90);
      drain(3000);
      vec_cnt++;
      if (le_pulses != exp_forced) begin
        err_cnt++; $display("FAIL random_len_err: round %0d got %0d pulses want %0d", rnd, le_pulses, exp_forced);
      end
    end
  endtask

  task automatic test_back_to_back();
    mode = 2'($urandom_range(3)); obs_log.delete();
    for (int s = 0; s < 4; s++) begin
      add_str(0, $urandom_range(1, 4), mode);
      add_str(1, $urandom_range(1, 4), mode);
    end
    valid_pct = 100; ready_pct = 100;
    drain(200);
    for (int k = 1; k < obs_log.size(); k++) begin
      vec_cnt++;
      if (obs_log[k-1].l ? (obs_log[k].cyc - obs_log[k-1].cyc != 2 || obs_log[k].s === obs_log[k-1].s)
                         : (obs_log[k].cyc - obs_log[k-1].cyc != 1 || obs_log[k].s !== obs_log[k-1].s)) begin
        err_cnt++; $display("FAIL b2b[%0d]: got gap %0d src %0d->%0d after last=%b, want gap %0d",
                            k, obs_log[k].cyc - obs_log[k-1].cyc, obs_log[k-1].s, obs_log[k].s,
                            obs_log[k-1].l, obs_log[k-1].l ? 2 : 1);
      end
    end
  endtask

  initial begin
    vec_cnt = 0; err_cnt = 0; cyc = 0; le_pulses = 0; exp_forced = 0; prev_stall = 1'b0; prev_snap = '0;
    mcnt[0] = 0; mcnt[1] = 0; mchg[0] = 0; mchg[1] = 0;
    valid_pct = 100; ready_pct = 100;
    test_reset();
    test_arb();
    test_upper();
    test_hold();
    test_maxlen();
    test_mode_switch();
    test_async_reset();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/case_conv_sched.md
Name: case_conv_sched

Overview:
Scheduler that shares one ASCII case-conversion datapath between two byte-stream requesters, such as the UART RX path (req 0) and the host write path (req 1). Grants one requester for a whole string, using round-robin between strings. Applies the conversion mode latched at grant time and presents converted bytes through a one-entry registered output with a valid/ready handshake. Also reports per-string character count and changed-character count.

Parameters:
MAX_LEN, 64, max bytes per string before a forced termination (>=2)
CNT_W, 7, width of count outputs; must hold MAX_LEN

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
mode  in  2  00 pass, 01 to-upper, 10 to-lower, 11 toggle case; sampled at grant only
req_valid  in  2  per-requester byte valid
req_data  in  16  byte for req i at [8i+7:8i]
req_last  in  2  per-requester end-of-string marker
req_ready  out  2  per-requester accept; one-hot or zero
out_valid  out  1  output byte valid
out_data  out  8  converted byte
out_last  out  1  last byte of string (real or forced)
out_src  out  1  requester index of current string
out_ready  in  1  downstream accept
str_cnt  out  CNT_W  bytes in string; valid with out_valid&out_last
chg_cnt  out  CNT_W  bytes altered by conversion; valid with out_valid&out_last
len_err  out  1  one-cycle pulse when a string is force-terminated at MAX_LEN
busy  out  1  high in STREAM

Behaviour:
- Reset (async assert, sync release): state IDLE, rr_ptr=0, output slot empty. All outputs are 0: out_valid, out_data, out_last, out_src, req_ready, str_cnt, chg_cnt, len_err, busy. Any in-flight byte is dropped, and no partial string resumes.
- Letter definition: 0x41-0x5A upper, 0x61-0x7A lower. Only bit 5 of a letter is ever modified. Non-letters always pass unchanged in every mode.
- FSM IDLE: req_ready=0. If any req_valid, grant=rr_ptr when req_valid[rr_ptr], else the other requester. Latch grant and mode, clear counters, go to STREAM next cycle. No byte is accepted in IDLE.
- FSM STREAM: req_ready[grant] = slot_free, where slot_free = !out_valid | out_ready. The other ready bit is 0.
- Accept occurs when req_valid[grant]&req_ready[grant]. The slot loads the converted byte next cycle, so latency is 1 cycle.
- str_cnt increments on each accept. chg_cnt increments when the converted byte differs from the input byte. Both values are presented alongside each byte and are meaningful only at out_last.
- An accept with req_last=1 sets out_last, returns to IDLE, and sets rr_ptr = ~grant.
- An accept that is the MAX_LEN-th byte without req_last sets out_last=1 and pulses len_err with that byte. It returns to IDLE and sets rr_ptr=~grant. Later bytes from that requester start a new string.
- Back-to-back: a full slot with out_ready=1 accepts a new byte in the same cycle, giving full throughput at 1 byte/cycle within a string. There is a 1-cycle bubble between strings, spent in IDLE.
- Output hold: while out_valid & !out_ready, out_data, out_last, out_src, str_cnt and chg_cnt are stable.
- The output slot may still hold the previous string's last byte while IDLE arbitrates. out_src and counters change only when the slot reloads.
- Changes to mode during STREAM take effect only at the next grant.
- A requester that drops req_valid mid-string stalls the stream. There is no timeout, and grant is held.
- busy=1 exactly while the state is STREAM.

Decomposition:
- Package case_conv_pkg: mode encodings (MODE_PASS/UPPER/LOWER/TOGGLE), state enum (ST_IDLE/ST_STREAM), letter range constants.
- Sub-module ascii_case_map: combinational, inputs byte and mode, outputs byte and changed flag. Gate-level style, with no clock.
- The scheduler holds the FSM, round-robin pointer, counters and output register.

Test Plan:
1. mode=01, req0 sends "a{Z" (0x61,0x7B,0x5A, last on 0x5A), out_ready=1 -> out_data 0x41,0x7B,0x5A on consecutive cycles; out_last on third; str_cnt=3, chg_cnt=1, out_src=0.
2. Both requesters valid in the same cycle after reset with 1-byte strings (req0 0x62 'b', req1 0x43 'C') under mode=11 -> req0 granted first and outputs 0x42; then req1 is granted after one IDLE cycle and outputs 0x63.
3. mode=10, req1 sends "AB". Hold out_ready=0 for 3 cycles after the first output -> out_data 0x61 is held stable, and req_ready=0 while the slot is full. After release, 0x62 follows the next cycle; no byte is lost or duplicated.
4. MAX_LEN=4, req0 sends 6 bytes with no last -> the 4th byte has out_last=1, len_err pulses once, str_cnt=4. Bytes 5-6 form a new string after re-arbitration. Req1 wins re-arbitration if it is valid.
5. Mode switched 01->00 mid-string on "xyz" -> all three bytes are uppercased (0x58,0x59,0x5A). The next string passes unchanged.
6. rst_n asserted low for 2 cycles mid-string, asynchronously, off a clock edge -> all outputs 0 immediately. After release the state is IDLE, rr_ptr=0, and the first new byte from req0 reports str_cnt=1.
